// File: rtl/save_ram_pkg.sv
// Shared types and helpers for the backup-RAM sector streamer.
package save_ram_pkg;

  localparam int unsigned SectorBitsDef = 9;
  localparam int unsigned RegionW       = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSeek,
    StReq,
    StXfer,
    StNext,
    StDone
  } state_e;

  // Number of sectors covered by a region byte mask.
  function automatic logic [31:0] sector_count(input logic [31:0] mask,
                                               input int unsigned sector_bits);
    return (mask >> sector_bits) + 32'd1;
  endfunction

endpackage

// File: rtl/save_ram_autosave.sv
// Per-region dirty flags and the idle timer that requests an autosave.
module save_ram_autosave #(
  parameter int unsigned NUM_REGIONS     = 2,
  parameter int unsigned AUTOSAVE_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   idle_i,
  input  logic [NUM_REGIONS-1:0] wr_i,
  input  logic [NUM_REGIONS-1:0] clr_i,
  input  logic                   clr_all_i,
  output logic [NUM_REGIONS-1:0] dirty_o,
  output logic                   fire_o
);

  localparam int unsigned TimerW = (AUTOSAVE_CYCLES < 2) ? 1 : $clog2(AUTOSAVE_CYCLES + 1);

  logic [NUM_REGIONS-1:0] dirty_q, dirty_d;
  logic [TimerW-1:0]      timer_q, timer_d;

  assign dirty_o = dirty_q;
  assign fire_o  = (AUTOSAVE_CYCLES != 0) && idle_i && (|dirty_q) &&
                   (timer_q == TimerW'(AUTOSAVE_CYCLES));

  always_comb begin
    // A write in the same cycle as a clear keeps the region dirty.
    dirty_d = ((clr_all_i ? '0 : dirty_q) & ~clr_i) | wr_i;
    timer_d = timer_q;
    if ((|wr_i) || fire_o) begin
      timer_d = '0;
    end else if (idle_i && (|dirty_q)) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dirty_q <= '0;
      timer_q <= '0;
    end else begin
      dirty_q <= dirty_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/save_ram_streamer.sv
// Walks the save regions back-to-back in LBA space, issuing one sd_rd/sd_wr
// handshake per sector, with dirty tracking, autosave and an ack watchdog.
module save_ram_streamer
  import save_ram_pkg::*;
#(
  parameter int unsigned NUM_REGIONS     = 2,
  parameter int unsigned SIZE_W          = 24,
  parameter int unsigned SECTOR_BITS     = SectorBitsDef,
  parameter int unsigned AUTOSAVE_CYCLES = 0,
  parameter int unsigned ACK_TIMEOUT     = 16777216
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REGIONS*SIZE_W-1:0] region_mask,
  input  logic                          load_req,
  input  logic                          save_req,
  input  logic                          download_end,
  input  logic [NUM_REGIONS-1:0]        mem_wr,
  input  logic                          sd_ack,
  output logic [31:0]                   sd_lba,
  output logic                          sd_rd,
  output logic                          sd_wr,
  output logic [RegionW-1:0]            region,
  output logic [SIZE_W-SECTOR_BITS-1:0] region_lba,
  output logic                          busy,
  output logic                          loading,
  output logic [NUM_REGIONS-1:0]        dirty,
  output logic                          done,
  output logic                          error
);

  localparam int unsigned WdW   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam int unsigned RlbaW = SIZE_W - SECTOR_BITS;

  state_e                 state_q, state_d;
  logic [3:0]             region_q, region_d;  // one extra bit marks "past last region"
  logic [31:0]            lba_q, lba_d;
  logic [RlbaW-1:0]       rlba_q, rlba_d;
  logic                   save_q, save_d;
  logic                   error_q, error_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic                   ld_q, sv_q, ack_q;

  logic [SIZE_W-1:0]      cur_mask;
  logic                   cur_present, last_sector, timed_out;
  logic                   load_start, save_start, fire, clr_all;
  logic [NUM_REGIONS-1:0] clr_region;

  always_comb begin
    cur_mask = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (region_q == 4'(r)) cur_mask = region_mask[r*SIZE_W +: SIZE_W];
    end
  end

  assign cur_present = |cur_mask;
  assign last_sector = (32'(rlba_q) + 32'd1) == sector_count(32'(cur_mask), SECTOR_BITS);
  assign timed_out   = (wd_q == WdW'(ACK_TIMEOUT - 1));
  assign load_start  = (load_req & ~ld_q) | download_end;
  assign save_start  = (save_req & ~sv_q) | fire;

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    lba_d    = lba_q;
    rlba_d   = rlba_q;
    save_d   = save_q;
    error_d  = error_q;
    wd_d     = (state_q == StReq || state_q == StXfer) ? wd_q + WdW'(1) : '0;
    clr_all  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (load_start || save_start)) begin
          state_d  = StSeek;
          save_d   = ~load_start;
          region_d = '0;
          lba_d    = '0;
          rlba_d   = '0;
          error_d  = 1'b0;
        end
      end
      StSeek: begin
        if (region_q >= 4'(NUM_REGIONS)) begin
          state_d = StDone;
        end else if (!cur_present) begin
          region_d = region_q + 4'd1;
        end else begin
          state_d = StReq;
          rlba_d  = '0;
        end
      end
      StReq: begin
        if (sd_ack && !ack_q) begin
          state_d = StXfer;
          wd_d    = '0;
        end else if (timed_out) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StXfer: begin
        if (!sd_ack && ack_q) begin
          state_d = StNext;
        end else if (timed_out) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StNext: begin
        // sd_lba always advances so it doubles as the next region's base.
        lba_d = lba_q + 32'd1;
        if (last_sector) begin
          region_d = region_q + 4'd1;
          state_d  = StSeek;
        end else begin
          rlba_d  = rlba_q + RlbaW'(1);
          state_d = StReq;
        end
      end
      StDone: begin
        state_d = StIdle;
        clr_all = ~save_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int r = 0; r < NUM_REGIONS; r++) begin
      clr_region[r] = (state_q == StSeek) && save_q && cur_present && (region_q == 4'(r));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= StIdle;
      region_q <= '0;
      lba_q    <= '0;
      rlba_q   <= '0;
      save_q   <= 1'b0;
      error_q  <= 1'b0;
      wd_q     <= '0;
      ld_q     <= load_req;
      sv_q     <= save_req;
      ack_q    <= sd_ack;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      lba_q    <= lba_d;
      rlba_q   <= rlba_d;
      save_q   <= save_d;
      error_q  <= error_d;
      wd_q     <= wd_d;
      ld_q     <= load_req;
      sv_q     <= save_req;
      ack_q    <= sd_ack;
    end
  end

  assign busy       = (state_q == StSeek) || (state_q == StReq) ||
                      (state_q == StXfer) || (state_q == StNext);
  assign loading    = busy & ~save_q;
  assign done       = (state_q == StDone);
  assign sd_rd      = (state_q == StReq) & ~save_q;
  assign sd_wr      = (state_q == StReq) & save_q;
  assign sd_lba     = lba_q;
  assign region     = region_q[RegionW-1:0];
  assign region_lba = rlba_q;
  assign error      = error_q;

  save_ram_autosave #(
    .NUM_REGIONS    (NUM_REGIONS),
    .AUTOSAVE_CYCLES(AUTOSAVE_CYCLES)
  ) u_autosave (
    .clk_i    (clk_sys),
    .rst_i    (reset),
    .idle_i   ((state_q == StIdle) && enable),
    .wr_i     (mem_wr & {NUM_REGIONS{~loading}}),
    .clr_i    (clr_region),
    .clr_all_i(clr_all),
    .dirty_o  (dirty),
    .fire_o   (fire)
  );

endmodule

// File: tb/tb_save_ram_streamer.sv
// Scoreboard bench: expected sector requests are queued by the stimulus and
// checked by a monitor as the streamer raises sd_rd/sd_wr.
module tb_save_ram_streamer;

  logic        clk = 1'b0;
  logic        reset, enable, load_req, save_req, download_end, sd_ack;
  logic [47:0] region_mask;
  logic [1:0]  mem_wr, dirty;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, done, error;
  logic [2:0]  region;
  logic [14:0] region_lba;

  int          checks = 0, errors = 0, done_cnt = 0, exp_done = 0;
  logic [63:0] exp_q[$];
  bit          req_prev = 0, ack_prev = 0, ack_en = 1, hold5 = 0;
  logic [34:0] cap = '0;

  always #5 clk = ~clk;

  save_ram_streamer #(
    .NUM_REGIONS    (2),
    .SIZE_W         (24),
    .SECTOR_BITS    (9),
    .AUTOSAVE_CYCLES(100),
    .ACK_TIMEOUT    (64)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .enable      (enable),
    .region_mask (region_mask),
    .load_req    (load_req),
    .save_req    (save_req),
    .download_end(download_end),
    .mem_wr      (mem_wr),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .region      (region),
    .region_lba  (region_lba),
    .busy        (busy),
    .loading     (loading),
    .dirty       (dirty),
    .done        (done),
    .error       (error)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] req_word(input bit wr, input int lba, input int rg,
                                           input int rl);
    return {12'd0, wr, ~wr, 3'(rg), 32'(lba), 15'(rl)};
  endfunction

  task automatic push_seq(input bit wr, input int lba0, input int rg, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(req_word(wr, lba0 + i, rg, i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_done();
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < 3000) begin
      step();
      n++;
    end
    check("done_count", 64'(done_cnt), 64'(exp_done));
  endtask

  // hps_io model: ack two cycles after a request, hold three cycles, release.
  initial begin
    sd_ack = 1'b0;
    forever begin
      step();
      if ((sd_rd || sd_wr) && ack_en && !sd_ack) begin
        bit h;
        h = hold5 && (sd_lba == 32'd5);
        repeat (2) @(posedge clk);
        #1 sd_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        while (h && hold5) step();
        sd_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit req_now;
    req_now = sd_rd || sd_wr;
    if (req_now && !req_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got lba %0d region %0d, required no request",
                 sd_lba, region);
      end else begin
        check("req", {12'd0, sd_wr, sd_rd, region, sd_lba, region_lba}, exp_q.pop_front());
      end
      check("req_loading", 64'(loading), 64'(sd_rd));
      cap = {region, sd_lba};
    end
    if (ack_prev && !sd_ack && busy) check("addr_stable", 64'({region, sd_lba}), 64'(cap));
    if (done) begin
      done_cnt++;
      check("done_idle", 64'({busy, loading}), 64'd0);
    end
    req_prev = req_now;
    ack_prev = sd_ack;
  end

  initial begin
    int cnt;
    bit seen;
    reset = 1'b1; enable = 1'b1; load_req = 1'b0; save_req = 1'b0;
    download_end = 1'b0; mem_wr = 2'b00;
    region_mask = {24'h0007FF, 24'h001FFF};
    repeat (2) step();
    reset = 1'b0;
    step();
    check("reset_outputs", 64'({busy, loading, sd_rd, sd_wr, done, error, dirty, region,
                                sd_lba, region_lba}), 64'd0);

    // Load of two regions; a pre-load write must be cleared by the load.
    mem_wr = 2'b10;
    step();
    mem_wr = 2'b00;
    check("dirty_set", 64'(dirty), 64'h2);
    push_seq(1'b0, 0, 0, 16);
    push_seq(1'b0, 16, 1, 4);
    download_end = 1'b1;
    step();
    download_end = 1'b0;
    check("start_state", 64'({busy, loading, sd_lba, region, region_lba}), {62'd0, 2'b11} << 50);
    step();
    check("first_rd", 64'(sd_rd), 64'd1);
    wait_done();
    check("load_clears_dirty", 64'(dirty), 64'd0);

    // Save with region 0 absent.
    region_mask = {24'h0007FF, 24'h000000};
    push_seq(1'b1, 0, 1, 4);
    save_req = 1'b1;
    wait_done();
    save_req = 1'b0;
    step();

    // Simultaneous edges: load wins; an edge while busy is dropped.
    region_mask = {24'h000000, 24'h0003FF};
    push_seq(1'b0, 0, 0, 2);
    load_req = 1'b1; save_req = 1'b1;
    step();
    check("both_busy", 64'({busy, loading}), 64'h3);
    load_req = 1'b0; save_req = 1'b0;
    step();
    save_req = 1'b1;
    wait_done();
    repeat (30) step();
    check("no_second_seq", 64'(done_cnt), 64'(exp_done));
    save_req = 1'b0;
    step();

    // Ack timeout.
    ack_en = 1'b0;
    push_seq(1'b0, 0, 0, 1);
    load_req = 1'b1;
    cnt = 0;
    while (!sd_rd && cnt < 10) begin step(); cnt++; end
    cnt = 0;
    while (sd_rd && cnt < 200) begin step(); cnt++; end
    check("timeout_len", 64'(cnt), 64'd64);
    check("timeout_flags", 64'({error, busy, loading}), 64'h4);
    check("timeout_no_done", 64'(done_cnt), 64'(exp_done));
    load_req = 1'b0;
    ack_en = 1'b1;
    step();
    push_seq(1'b0, 0, 0, 2);
    load_req = 1'b1;
    step();
    check("error_cleared", 64'({error, busy}), 64'h1);
    wait_done();
    load_req = 1'b0;

    // Autosave after 100 idle cycles from the last write.
    region_mask = {24'h0007FF, 24'h001FFF};
    reset_dut();
    push_seq(1'b1, 0, 0, 16);
    push_seq(1'b1, 16, 1, 4);
    mem_wr = 2'b01;
    step();
    mem_wr = 2'b00;
    repeat (49) @(posedge clk);
    #1 mem_wr = 2'b01;
    step();
    mem_wr = 2'b00;
    cnt = 51;
    while (!busy && cnt < 400) begin step(); cnt++; end
    check("autosave_start", 64'(cnt), 64'd152);
    cnt = 0;
    while (!(sd_wr && region == 3'd0) && cnt < 50) begin step(); cnt++; end
    mem_wr = 2'b01;
    step();
    mem_wr = 2'b00;
    wait_done();
    check("dirty_after_save", 64'(dirty), 64'h1);
    reset_dut();

    // Reset while the LBA 5 transfer is in XFER, with load_req held high.
    hold5 = 1'b1;
    push_seq(1'b0, 0, 0, 6);
    load_req = 1'b1;
    cnt = 0;
    while (!(busy && sd_ack && !sd_rd && sd_lba == 32'd5) && cnt < 400) begin
      step();
      cnt++;
    end
    check("reached_lba5", 64'(sd_lba), 64'd5);
    reset = 1'b1;
    step();
    check("reset_mid_xfer", 64'({busy, loading, sd_rd, sd_wr, done, error, dirty, region,
                                 sd_lba, region_lba}), 64'd0);
    reset = 1'b0;
    hold5 = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (busy) seen = 1'b1;
    end
    check("no_restart", 64'(seen), 64'd0);
    load_req = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
